// File: rtl/screen_buffer_pkg.sv
// Shared frame geometry and pixel/address types for the renderer and screen_buffer.
package screen_buffer_pkg;

    localparam int FRAME_WIDTH  = 256;
    localparam int FRAME_HEIGHT = 128;
    localparam int FRAME_AREA   = FRAME_WIDTH * FRAME_HEIGHT;
    localparam int FX_W         = $clog2(FRAME_WIDTH);
    localparam int FY_W         = $clog2(FRAME_HEIGHT);
    localparam int ADDR_W       = $clog2(FRAME_AREA);

    typedef logic [15:0]       pixel_t;
    typedef logic [ADDR_W-1:0] frame_addr_t;

    typedef enum logic [1:0] {
        NO_FRAME,
        DRAWING,
        PENDING
    } sbuf_state_t;

    // Row-major address by concatenation; both dimensions are powers of two.
    function automatic frame_addr_t frame_addr(input logic [FX_W-1:0] fx,
                                               input logic [FY_W-1:0] fy);
        return {fy, fx};
    endfunction

endpackage

// File: rtl/screen_buffer_bank.sv
// sbuf_bank: one frame of simple dual-port BRAM, registered read output (latency 1).
module sbuf_bank
    import screen_buffer_pkg::*;
(
    input  logic        clk_in,
    input  logic        wr_en,
    input  frame_addr_t wr_addr,
    input  pixel_t      wr_data,
    input  logic        rd_en,
    input  frame_addr_t rd_addr,
    output pixel_t      rd_data
);

    pixel_t mem [FRAME_AREA];
    pixel_t rd_data_q;

    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/screen_buffer.sv
// Double-buffered RGB565 frame store with upscaled, bordered read port.
// Optional SBUF_TEST_PATTERN_EN: gradient test pattern in NO_FRAME for in-frame reads.
module screen_buffer
    import screen_buffer_pkg::*;
#(
    parameter int          SCALE_SHIFT  = 2,
    parameter logic [15:0] BORDER_COLOR = 16'h0000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [15:0] wr_data,
    input  logic [15:0] wr_addr,
    input  logic        wr_en,
    input  logic        frame_done,
    output logic        back_ready,
    input  logic [10:0] rd_x,
    input  logic [9:0]  rd_y,
    input  logic        rd_en,
    input  logic        vsync_in,
    output logic [15:0] rd_pixel,
    output logic        rd_valid,
    output logic        front_bank
);

    sbuf_state_t state_q, state_d;
    logic        front_bank_q, front_bank_d;

    logic        valid1_q, valid1_d;
    logic        in_frame1_q, in_frame1_d;
    logic        no_frame1_q, no_frame1_d;
    logic        bank1_q, bank1_d;
    logic        rd_valid_q, rd_valid_d;
    pixel_t      rd_pixel_q, rd_pixel_d;

    logic [10:0] fx_full;
    logic [9:0]  fy_full;
    frame_addr_t rd_addr;
    logic        wr_ok;
    pixel_t      bank0_data, bank1_data;

`ifdef SBUF_TEST_PATTERN_EN
    pixel_t      pattern1_q, pattern1_d;
`endif

    always_comb begin
        state_d      = state_q;
        front_bank_d = front_bank_q;
        unique case (state_q)
            NO_FRAME, DRAWING: begin
                if (frame_done) state_d = PENDING;
            end
            PENDING: begin
                if (vsync_in) begin
                    state_d      = DRAWING;
                    front_bank_d = ~front_bank_q;
                end
            end
            default: state_d = NO_FRAME;
        endcase
    end

    assign back_ready = (state_q != PENDING);
    assign front_bank = front_bank_q;

    // Out-of-range addresses must be rejected, not truncated into the frame.
    assign wr_ok = wr_en && back_ready && (wr_addr[15:ADDR_W] == '0);

    assign fx_full = rd_x >> SCALE_SHIFT;
    assign fy_full = rd_y >> SCALE_SHIFT;
    assign rd_addr = frame_addr(fx_full[FX_W-1:0], fy_full[FY_W-1:0]);

    sbuf_bank u_bank0 (
        .clk_in  (clk_in),
        .wr_en   (wr_ok && front_bank_q),
        .wr_addr (wr_addr[ADDR_W-1:0]),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (bank0_data)
    );

    sbuf_bank u_bank1 (
        .clk_in  (clk_in),
        .wr_en   (wr_ok && !front_bank_q),
        .wr_addr (wr_addr[ADDR_W-1:0]),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (bank1_data)
    );

    // Bank select is captured with the address so in-flight reads survive a swap.
    always_comb begin
        valid1_d    = rd_en;
        in_frame1_d = (fx_full[10:FX_W] == '0) && (fy_full[9:FY_W] == '0);
        no_frame1_d = (state_q == NO_FRAME);
        bank1_d     = front_bank_q;
`ifdef SBUF_TEST_PATTERN_EN
        pattern1_d  = {fx_full[4:0], fy_full[5:0], fx_full[4:0]};
`endif

        rd_valid_d = valid1_q;
        rd_pixel_d = rd_pixel_q;
        if (valid1_q) begin
            if (!in_frame1_q) begin
                rd_pixel_d = BORDER_COLOR;
            end else if (no_frame1_q) begin
`ifdef SBUF_TEST_PATTERN_EN
                rd_pixel_d = pattern1_q;
`else
                rd_pixel_d = BORDER_COLOR;
`endif
            end else begin
                rd_pixel_d = bank1_q ? bank1_data : bank0_data;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= NO_FRAME;
            front_bank_q <= 1'b0;
            valid1_q     <= 1'b0;
            in_frame1_q  <= 1'b0;
            no_frame1_q  <= 1'b1;
            bank1_q      <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_pixel_q   <= '0;
`ifdef SBUF_TEST_PATTERN_EN
            pattern1_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            front_bank_q <= front_bank_d;
            valid1_q     <= valid1_d;
            in_frame1_q  <= in_frame1_d;
            no_frame1_q  <= no_frame1_d;
            bank1_q      <= bank1_d;
            rd_valid_q   <= rd_valid_d;
            rd_pixel_q   <= rd_pixel_d;
`ifdef SBUF_TEST_PATTERN_EN
            pattern1_q   <= pattern1_d;
`endif
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_pixel = rd_pixel_q;

endmodule

// File: tb/tb_screen_buffer.sv
// Directed self-checking bench for screen_buffer: swap FSM, write filtering, read pipeline.
module tb_screen_buffer;

    logic        clk;
    logic        rst_in;
    logic [15:0] wr_data;
    logic [15:0] wr_addr;
    logic        wr_en;
    logic        frame_done;
    logic        back_ready;
    logic [10:0] rd_x;
    logic [9:0]  rd_y;
    logic        rd_en;
    logic        vsync_in;
    logic [15:0] rd_pixel;
    logic        rd_valid;
    logic        front_bank;

    int checks   = 0;
    int failures = 0;

    screen_buffer dut (
        .clk_in     (clk),
        .rst_in     (rst_in),
        .wr_data    (wr_data),
        .wr_addr    (wr_addr),
        .wr_en      (wr_en),
        .frame_done (frame_done),
        .back_ready (back_ready),
        .rd_x       (rd_x),
        .rd_y       (rd_y),
        .rd_en      (rd_en),
        .vsync_in   (vsync_in),
        .rd_pixel   (rd_pixel),
        .rd_valid   (rd_valid),
        .front_bank (front_bank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required $finish before it");
        $fatal(1, "watchdog");
    end

    task automatic do_write(input logic [15:0] addr, input logic [15:0] data);
        @(negedge clk);
        wr_addr = addr;
        wr_data = data;
        wr_en   = 1'b1;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic do_read(input logic [10:0] x, input logic [9:0] y,
                           output logic [15:0] pix, output logic vld);
        @(negedge clk);
        rd_x  = x;
        rd_y  = y;
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        @(negedge clk);
        pix = rd_pixel;
        vld = rd_valid;
    endtask

    task automatic pulse_frame_done();
        @(negedge clk);
        frame_done = 1'b1;
        @(negedge clk);
        frame_done = 1'b0;
    endtask

    task automatic pulse_vsync();
        @(negedge clk);
        vsync_in = 1'b1;
        @(negedge clk);
        vsync_in = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] pix;
        logic        vld;
        logic [15:0] exp_pat;
        rst_in = 1'b1;
        repeat (3) @(negedge clk);
        rst_in = 1'b0;
        @(negedge clk);
        checks++;
        if (rd_valid !== 1'b0 || rd_pixel !== 16'h0000 || front_bank !== 1'b0 || back_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_state: got valid=%b pixel=%h front=%b ready=%b, required 0/0000/0/1",
                     rd_valid, rd_pixel, front_bank, back_ready);
        end
        do_read(11'd0, 10'd0, pix, vld);
        checks++;
        if (vld !== 1'b1 || pix !== 16'h0000) begin
            failures++;
            $display("FAIL reset_read_origin: got valid=%b pixel=%h, required 1/0000", vld, pix);
        end
`ifdef SBUF_TEST_PATTERN_EN
        exp_pat = {5'd10, 6'd5, 5'd10};
`else
        exp_pat = 16'h0000;
`endif
        do_read(11'd40, 10'd20, pix, vld);
        checks++;
        if (vld !== 1'b1 || pix !== exp_pat) begin
            failures++;
            $display("FAIL no_frame_read_40_20: got valid=%b pixel=%h, required 1/%h", vld, pix, exp_pat);
        end
    endtask

    task automatic test_frame_swap();
        logic [15:0] pix;
        logic        vld;
        do_write(16'd0, 16'hF800);
        do_write(16'd32767, 16'h07E0);
        do_write(16'd5, 16'h1234);
        pulse_frame_done();
        checks++;
        if (back_ready !== 1'b0) begin
            failures++;
            $display("FAIL pending_back_ready: got %b, required 0", back_ready);
        end
        do_write(16'd5, 16'h001F);
        pulse_vsync();
        checks++;
        if (front_bank !== 1'b1 || back_ready !== 1'b1) begin
            failures++;
            $display("FAIL swap: got front=%b ready=%b, required 1/1", front_bank, back_ready);
        end
        do_read(11'd0, 10'd0, pix, vld);
        checks++;
        if (vld !== 1'b1 || pix !== 16'hF800) begin
            failures++;
            $display("FAIL read_addr0: got valid=%b pixel=%h, required 1/F800", vld, pix);
        end
        do_read(11'd1023, 10'd511, pix, vld);
        checks++;
        if (vld !== 1'b1 || pix !== 16'h07E0) begin
            failures++;
            $display("FAIL read_last_pixel: got valid=%b pixel=%h, required 1/07E0", vld, pix);
        end
        do_read(11'd20, 10'd0, pix, vld);
        checks++;
        if (vld !== 1'b1 || pix !== 16'h1234) begin
            failures++;
            $display("FAIL pending_write_dropped: got valid=%b pixel=%h, required 1/1234", vld, pix);
        end
    endtask

    task automatic test_border_and_range();
        logic [15:0] pix;
        logic        vld;
        do_write(16'd32767, 16'hAAAA);
        do_write(16'hFFFF, 16'h5555);
        pulse_frame_done();
        pulse_vsync();
        checks++;
        if (front_bank !== 1'b0) begin
            failures++;
            $display("FAIL second_swap: got front=%b, required 0", front_bank);
        end
        do_read(11'd1023, 10'd511, pix, vld);
        checks++;
        if (vld !== 1'b1 || pix !== 16'hAAAA) begin
            failures++;
            $display("FAIL no_alias_ffff: got valid=%b pixel=%h, required 1/AAAA", vld, pix);
        end
        @(negedge clk);
        checks++;
        if (rd_valid !== 1'b0 || rd_pixel !== 16'hAAAA) begin
            failures++;
            $display("FAIL idle_hold: got valid=%b pixel=%h, required 0/AAAA", rd_valid, rd_pixel);
        end
        do_read(11'd1024, 10'd0, pix, vld);
        checks++;
        if (vld !== 1'b1 || pix !== 16'h0000) begin
            failures++;
            $display("FAIL border_x1024: got valid=%b pixel=%h, required 1/0000", vld, pix);
        end
        do_read(11'd0, 10'd512, pix, vld);
        checks++;
        if (vld !== 1'b1 || pix !== 16'h0000) begin
            failures++;
            $display("FAIL border_y512: got valid=%b pixel=%h, required 1/0000", vld, pix);
        end
    endtask

    task automatic test_same_cycle();
        @(negedge clk);
        frame_done = 1'b1;
        vsync_in   = 1'b1;
        @(negedge clk);
        frame_done = 1'b0;
        vsync_in   = 1'b0;
        checks++;
        if (front_bank !== 1'b0 || back_ready !== 1'b0) begin
            failures++;
            $display("FAIL same_cycle_done_vsync: got front=%b ready=%b, required 0/0", front_bank, back_ready);
        end
        pulse_frame_done();
        checks++;
        if (front_bank !== 1'b0 || back_ready !== 1'b0) begin
            failures++;
            $display("FAIL done_in_pending: got front=%b ready=%b, required 0/0", front_bank, back_ready);
        end
        pulse_vsync();
        checks++;
        if (front_bank !== 1'b1 || back_ready !== 1'b1) begin
            failures++;
            $display("FAIL next_vsync_swap: got front=%b ready=%b, required 1/1", front_bank, back_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_pix;
        do_write(16'd0, 16'h1111);
        pulse_frame_done();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                exp_pix = ((i - 2) <= 3) ? 16'hF800 : 16'h1111;
                checks++;
                if (rd_valid !== 1'b1 || rd_pixel !== exp_pix) begin
                    failures++;
                    $display("FAIL stream_read_%0d: got valid=%b pixel=%h, required 1/%h",
                             i - 2, rd_valid, rd_pixel, exp_pix);
                end
            end
            rd_x     = 11'd0;
            rd_y     = 10'd0;
            rd_en    = (i < 8);
            vsync_in = (i == 3);
        end
        rd_en    = 1'b0;
        vsync_in = 1'b0;
        checks++;
        if (front_bank !== 1'b0) begin
            failures++;
            $display("FAIL stream_swap: got front=%b, required 0", front_bank);
        end
    endtask

    task automatic test_reset_midstream();
        logic [15:0] pix;
        logic        vld;
        @(negedge clk);
        rd_x  = 11'd0;
        rd_y  = 10'd0;
        rd_en = 1'b1;
        repeat (3) @(negedge clk);
        rst_in = 1'b1;
        @(negedge clk);
        checks++;
        if (rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_flush: got valid=%b, required 0", rd_valid);
        end
        rd_en  = 1'b0;
        rst_in = 1'b0;
        @(negedge clk);
        checks++;
        if (front_bank !== 1'b0 || back_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_fsm: got front=%b ready=%b, required 0/1", front_bank, back_ready);
        end
        do_read(11'd0, 10'd0, pix, vld);
        checks++;
        if (vld !== 1'b1 || pix !== 16'h0000) begin
            failures++;
            $display("FAIL reset_no_frame_read: got valid=%b pixel=%h, required 1/0000", vld, pix);
        end
    endtask

    initial begin
        rst_in     = 1'b1;
        wr_data    = '0;
        wr_addr    = '0;
        wr_en      = 1'b0;
        frame_done = 1'b0;
        rd_x       = '0;
        rd_y       = '0;
        rd_en      = 1'b0;
        vsync_in   = 1'b0;

        test_reset();
        test_frame_swap();
        test_border_and_range();
        test_same_cycle();
        test_back_to_back();
        test_reset_midstream();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
